// File: rtl/fetch_pc_pipeline_pkg.sv
// Shared defaults and fetch-action decode for the fetch front-end and PC shadow pipeline.
`ifndef FETCH_PC_PIPELINE_RESET_PC_DEFAULT
`define FETCH_PC_PIPELINE_RESET_PC_DEFAULT 32'h0000_0000
`endif

package fetch_pc_pipeline_pkg;

  localparam int unsigned DEF_ADDR_WIDTH  = 32;
  localparam int unsigned DEF_INSTR_WIDTH = 32;
  localparam int unsigned DEF_DEPTH       = 4;
  localparam int unsigned DEF_STEP        = 4;
  localparam int unsigned DEF_CNT_WIDTH   = 16;
  localparam logic [31:0] DEF_RESET_PC    = `FETCH_PC_PIPELINE_RESET_PC_DEFAULT;

  typedef enum logic [1:0] {
    ACT_SEQ      = 2'd0,
    ACT_REDIRECT = 2'd1,
    ACT_STALL    = 2'd2
  } fetch_act_e;

  // Stall dominates; a redirect seen under stall is dropped, decode must re-present it.
  function automatic fetch_act_e decode_act(input logic stall, input logic redirect_valid);
    if (stall)               return ACT_STALL;
    else if (redirect_valid) return ACT_REDIRECT;
    else                     return ACT_SEQ;
  endfunction

endpackage

// File: rtl/fetch_pc_pipeline_if.sv
// Instruction-memory and decode-facing signals of the fetch front-end.
interface fetch_pc_pipeline_if #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   stall;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic [INSTR_WIDTH-1:0] id_instr;
  logic [ADDR_WIDTH-1:0]  id_pc;
  logic                   id_valid;

  modport master (
    output imem_addr, id_instr, id_pc, id_valid,
    input  imem_rdata, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, id_instr, id_pc, id_valid,
    output imem_rdata, stall, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_pc_pipeline_pc_shadow_stage.sv
// One PC shadow stage: pc plus valid register that either loads its upstream or takes a bubble.
module fetch_pc_pipeline_pc_shadow_stage #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bubble,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic                  in_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  valid
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      pc    <= '0;
      valid <= 1'b0;
    end else begin
      pc    <= in_pc;
      valid <= in_valid;
    end
  end

endmodule

// File: rtl/fetch_pc_pipeline.sv
// Fetch PC generator, IF/ID instruction register and DEPTH-stage PC shadow pipeline
// with saturating retire and bubble counters.
module fetch_pc_pipeline
  import fetch_pc_pipeline_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned           INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int unsigned           DEPTH       = DEF_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(DEF_RESET_PC),
  parameter int unsigned           STEP        = DEF_STEP,
  parameter int unsigned           CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  fetch_pc_pipeline_if.master         bus,
  output logic [DEPTH*ADDR_WIDTH-1:0] stage_pc,
  output logic [DEPTH-1:0]            stage_valid,
  output logic [ADDR_WIDTH-1:0]       retire_pc,
  output logic                        retire_valid,
  output logic [CNT_WIDTH-1:0]        retire_count,
  output logic [CNT_WIDTH-1:0]        bubble_count
);

  fetch_act_e             act;
  logic [ADDR_WIDTH-1:0]  fetch_pc, fetch_pc_nxt;
  logic [INSTR_WIDTH-1:0] id_instr_q, id_instr_nxt;
  logic [ADDR_WIDTH-1:0]  id_pc_q, id_pc_nxt;
  logic                   id_valid_q, id_valid_nxt;
  logic                   bubble_inc;
  logic [CNT_WIDTH-1:0]   retire_count_q, bubble_count_q;

  // Next fetch/IF-ID state for the three edge cases.
  always_comb begin
    act          = decode_act(bus.stall, bus.redirect_valid);
    fetch_pc_nxt = fetch_pc;
    id_instr_nxt = id_instr_q;
    id_pc_nxt    = id_pc_q;
    id_valid_nxt = id_valid_q;
    bubble_inc   = 1'b0;
    case (act)
      ACT_STALL: begin
        bubble_inc = id_valid_q;
      end
      ACT_REDIRECT: begin
        // The fetch in flight is wrong-path: capture it but mark it dead.
        fetch_pc_nxt = bus.redirect_pc;
        id_instr_nxt = bus.imem_rdata;
        id_pc_nxt    = fetch_pc;
        id_valid_nxt = 1'b0;
        bubble_inc   = 1'b1;
      end
      default: begin
        fetch_pc_nxt = fetch_pc + ADDR_WIDTH'(STEP);
        id_instr_nxt = bus.imem_rdata;
        id_pc_nxt    = fetch_pc;
        id_valid_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc   <= RESET_PC;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      fetch_pc   <= fetch_pc_nxt;
      id_instr_q <= id_instr_nxt;
      id_pc_q    <= id_pc_nxt;
      id_valid_q <= id_valid_nxt;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_count_q <= '0;
      bubble_count_q <= '0;
    end else begin
      if (retire_valid && !(&retire_count_q))
        retire_count_q <= retire_count_q + CNT_WIDTH'(1);
      if (bubble_inc && !(&bubble_count_q))
        bubble_count_q <= bubble_count_q + CNT_WIDTH'(1);
    end
  end

  logic [ADDR_WIDTH-1:0] st_pc [DEPTH];
  logic [DEPTH-1:0]      st_valid;

  // Stage 1 is fed from ID and takes the stall bubble; later stages always shift.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [ADDR_WIDTH-1:0] in_pc;
    logic                  in_valid;
    logic                  bubble;

    if (k == 0) begin : g_head
      assign in_pc    = id_pc_q;
      assign in_valid = id_valid_q;
      assign bubble   = bus.stall;
    end else begin : g_body
      assign in_pc    = st_pc[k-1];
      assign in_valid = st_valid[k-1];
      assign bubble   = 1'b0;
    end

    fetch_pc_pipeline_pc_shadow_stage #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .bubble   (bubble),
      .in_pc    (in_pc),
      .in_valid (in_valid),
      .pc       (st_pc[k]),
      .valid    (st_valid[k])
    );

    assign stage_pc[k*ADDR_WIDTH +: ADDR_WIDTH] = st_pc[k];
  end

  assign bus.imem_addr = fetch_pc;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_valid  = id_valid_q;
  assign stage_valid   = st_valid;
  assign retire_pc     = st_pc[DEPTH-1];
  assign retire_valid  = st_valid[DEPTH-1];
  assign retire_count  = retire_count_q;
  assign bubble_count  = bubble_count_q;

endmodule

// File: tb/tb_fetch_pc_pipeline.sv
// Bench for fetch_pc_pipeline: two instances (default, and wrapping reset PC with 4-bit counters)
// driven in lock-step and compared against a queue-style reference model every cycle.
module tb_fetch_pc_pipeline;

  localparam int unsigned AW = 32;
  localparam int unsigned IW = 32;
  localparam int unsigned D  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          stall;
  logic          rv;
  logic [AW-1:0] rpc;

  fetch_pc_pipeline_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus_a ();
  fetch_pc_pipeline_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus_b ();

  assign bus_a.imem_rdata     = bus_a.imem_addr ^ 32'hA5A5_0000;
  assign bus_a.stall          = stall;
  assign bus_a.redirect_valid = rv;
  assign bus_a.redirect_pc    = rpc;
  assign bus_b.imem_rdata     = bus_b.imem_addr ^ 32'hA5A5_0000;
  assign bus_b.stall          = stall;
  assign bus_b.redirect_valid = rv;
  assign bus_b.redirect_pc    = rpc;

  logic [D*AW-1:0] spc_a, spc_b;
  logic [D-1:0]    sv_a, sv_b;
  logic [AW-1:0]   rpc_a, rpc_b;
  logic            rval_a, rval_b;
  logic [15:0]     rcnt_a, bcnt_a;
  logic [3:0]      rcnt_b, bcnt_b;

  fetch_pc_pipeline #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(D),
    .RESET_PC(32'h0000_0000), .STEP(4), .CNT_WIDTH(16)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.master),
    .stage_pc(spc_a), .stage_valid(sv_a), .retire_pc(rpc_a), .retire_valid(rval_a),
    .retire_count(rcnt_a), .bubble_count(bcnt_a)
  );

  fetch_pc_pipeline #(
    .ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(D),
    .RESET_PC(32'hFFFF_FFFC), .STEP(4), .CNT_WIDTH(4)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.master),
    .stage_pc(spc_b), .stage_valid(sv_b), .retire_pc(rpc_b), .retire_valid(rval_b),
    .retire_count(rcnt_b), .bubble_count(bcnt_b)
  );

  // Reference model: per instance, fetch PC, ID slot, a D-entry PC/valid pipe, counters.
  logic [31:0] m_fpc   [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_ipc   [2];
  logic        m_ival  [2];
  logic [31:0] m_spc   [2][D];
  logic        m_sval  [2][D];
  int unsigned m_ret   [2];
  int unsigned m_bub   [2];

  int nvec = 0;
  int nerr = 0;

  function automatic int unsigned cmax(input int i);
    return (i == 0) ? 32'd65535 : 32'd15;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_fpc[i]   = (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
      m_instr[i] = '0;
      m_ipc[i]   = '0;
      m_ival[i]  = 1'b0;
      m_ret[i]   = 0;
      m_bub[i]   = 0;
      for (int k = 0; k < D; k++) begin
        m_spc[i][k]  = '0;
        m_sval[i][k] = 1'b0;
      end
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (m_sval[i][D-1] && m_ret[i] < cmax(i)) m_ret[i]++;
      for (int k = D - 1; k > 0; k--) begin
        m_spc[i][k]  = m_spc[i][k-1];
        m_sval[i][k] = m_sval[i][k-1];
      end
      if (stall) begin
        m_spc[i][0]  = '0;
        m_sval[i][0] = 1'b0;
        if (m_ival[i] && m_bub[i] < cmax(i)) m_bub[i]++;
      end else begin
        m_spc[i][0]  = m_ipc[i];
        m_sval[i][0] = m_ival[i];
        m_instr[i]   = m_fpc[i] ^ 32'hA5A5_0000;
        m_ipc[i]     = m_fpc[i];
        if (rv) begin
          m_ival[i] = 1'b0;
          m_fpc[i]  = rpc;
          if (m_bub[i] < cmax(i)) m_bub[i]++;
        end else begin
          m_ival[i] = 1'b1;
          m_fpc[i]  = m_fpc[i] + 32'd4;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_imem_addr", 64'(bus_a.imem_addr), 64'(m_fpc[0]));
    chk("a_id_instr",  64'(bus_a.id_instr),  64'(m_instr[0]));
    chk("a_id_pc",     64'(bus_a.id_pc),     64'(m_ipc[0]));
    chk("a_id_valid",  64'(bus_a.id_valid),  64'(m_ival[0]));
    chk("b_imem_addr", 64'(bus_b.imem_addr), 64'(m_fpc[1]));
    chk("b_id_instr",  64'(bus_b.id_instr),  64'(m_instr[1]));
    chk("b_id_pc",     64'(bus_b.id_pc),     64'(m_ipc[1]));
    chk("b_id_valid",  64'(bus_b.id_valid),  64'(m_ival[1]));
    for (int k = 0; k < D; k++) begin
      chk($sformatf("a_stage%0d_pc", k + 1),    64'(spc_a[k*AW +: AW]), 64'(m_spc[0][k]));
      chk($sformatf("a_stage%0d_valid", k + 1), 64'(sv_a[k]),           64'(m_sval[0][k]));
      chk($sformatf("b_stage%0d_pc", k + 1),    64'(spc_b[k*AW +: AW]), 64'(m_spc[1][k]));
      chk($sformatf("b_stage%0d_valid", k + 1), 64'(sv_b[k]),           64'(m_sval[1][k]));
    end
    chk("a_retire_pc",    64'(rpc_a),  64'(m_spc[0][D-1]));
    chk("a_retire_valid", 64'(rval_a), 64'(m_sval[0][D-1]));
    chk("b_retire_pc",    64'(rpc_b),  64'(m_spc[1][D-1]));
    chk("b_retire_valid", 64'(rval_b), 64'(m_sval[1][D-1]));
    chk("a_retire_count", 64'(rcnt_a), 64'(m_ret[0]));
    chk("a_bubble_count", 64'(bcnt_a), 64'(m_bub[0]));
    chk("b_retire_count", 64'(rcnt_b), 64'(m_ret[1]));
    chk("b_bubble_count", 64'(bcnt_b), 64'(m_bub[1]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    logic        seen12;
    logic [31:0] hold_pc;
    stall = 1'b0;
    rv    = 1'b0;
    rpc   = '0;

    #1 reset = 1'b0;
    model_reset();
    #1 check_all();
    chk("a_reset_imem_addr", 64'(bus_a.imem_addr), 64'h0);
    chk("b_reset_imem_addr", 64'(bus_b.imem_addr), 64'hFFFF_FFFC);
    @(negedge clk) reset = 1'b1;

    // Sequential fetch from the reset vector.
    step();
    chk("a_e1_id_pc",    64'(bus_a.id_pc),    64'h0);
    chk("a_e1_id_instr", 64'(bus_a.id_instr), 64'hA5A5_0000);
    chk("a_e1_id_valid", 64'(bus_a.id_valid), 64'h1);
    chk("b_e1_imem_addr", 64'(bus_b.imem_addr), 64'h0);
    step();
    chk("b_e2_imem_addr", 64'(bus_b.imem_addr), 64'h4);
    step();
    chk("a_e3_id_pc", 64'(bus_a.id_pc), 64'h8);

    // Two-cycle stall with id_pc=8.
    stall = 1'b1;
    step();
    step();
    chk("a_stall_fetch_pc", 64'(bus_a.imem_addr), 64'hC);
    chk("a_stall_id_pc",    64'(bus_a.id_pc),     64'h8);
    chk("a_stall_bubbles",  64'(bcnt_a),          64'h2);

    // Redirect to 0x100 while id_pc=8.
    stall = 1'b0;
    rv    = 1'b1;
    rpc   = 32'h0000_0100;
    step();
    chk("a_redir_imem_addr", 64'(bus_a.imem_addr), 64'h100);
    chk("a_redir_id_valid",  64'(bus_a.id_valid),  64'h0);
    chk("a_redir_stage1",    64'({spc_a[AW-1:0], sv_a[0]}), {31'h0, 32'h8, 1'b1});
    rv = 1'b0;
    step();
    chk("a_redir_id_pc",    64'(bus_a.id_pc),    64'h100);
    chk("a_redir_id_valid2", 64'(bus_a.id_valid), 64'h1);
    seen12 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (rval_a && rpc_a == 32'hC) seen12 = 1'b1;
    end
    chk("a_pc12_never_retires", 64'(seen12), 64'h0);

    // Redirect presented under stall is ignored, then taken once stall drops.
    hold_pc = m_fpc[0];
    stall = 1'b1;
    rv    = 1'b1;
    rpc   = 32'h0000_0200;
    step();
    chk("a_stall_redirect_hold", 64'(bus_a.imem_addr), 64'(hold_pc));
    stall = 1'b0;
    step();
    chk("a_redirect_after_stall", 64'(bus_a.imem_addr), 64'h200);
    rv = 1'b0;

    // Long sequential run saturates the 4-bit retire counter.
    for (int n = 0; n < 25; n++) step();
    chk("b_retire_count_sat", 64'(rcnt_b), 64'hF);

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    chk("a_async_reset_valid", 64'(sv_a), 64'h0);
    @(negedge clk) reset = 1'b1;

    // Randomized stall/redirect traffic.
    for (int n = 0; n < 300; n++) begin
      stall = ($urandom % 4) == 0;
      rv    = ($urandom % 5) == 0;
      rpc   = {$urandom() >> 2, 2'b00} & 32'hFFFF_FFFC;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
